mux_25bit_2way: RTL and testbench
=================================

Name: mux_25bit_2way

Overview:
- 25-bit, two-input word multiplexer used in the two-mode timer to choose between two 25-bit terminal-count/preset values.
- sel chooses which one reaches the counter compare logic.
- Primary output is purely combinational, so the choice is visible in the same timestep the inputs change.
- A registered copy of the output is also provided for downstream logic that needs a clocked value.

Parameters:
- WIDTH, 25, data width of in1, in2, out, out_q.

Ports:
- clk    input   1      single system clock; out_q and sel_q update on its rising edge
- rst    input   1      synchronous, active-high reset
- in1    input   WIDTH  data word selected when sel = 0
- in2    input   WIDTH  data word selected when sel = 1
- sel    input   1      select: 0 -> in1, 1 -> in2
- out    output  WIDTH  combinational selected word
- out_q  output  WIDTH  registered copy of out, one-cycle latency
- sel_q  output  1      registered copy of sel, aligned with out_q

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Combinational path: out = sel ? in2 : in1 at all times.
  - Zero clock latency; no dependence on clk or rst.
  - out responds within the same delta/timestep to any change on in1, in2 or sel.
  - rst does NOT force out; out tracks the inputs even while rst = 1.
- Select is exactly one bit; no X-propagation handling beyond the language default.
- Width rules:
  - Inputs are passed unmodified and unsigned.
  - No truncation, extension or arithmetic.
  - All WIDTH bits are routed independently.
- Registered path, evaluated on each rising clk edge:
  - rst = 1: out_q <= 0, sel_q <= 0.
  - Otherwise: out_q <= (sel ? in2 : in1) and sel_q <= sel, sampled at that edge.
  - Latency is one cycle from input change to out_q.
- Reset values: out_q = 0 and sel_q = 0. out has no reset value (combinational).
- Simultaneous events: changing sel, in1 and in2 together still gives out = the newly selected input; no glitch requirement beyond functional correctness.
- Reset mid-operation: the next rising edge with rst = 1 clears out_q/sel_q. The first edge after rst deasserts loads the current selection.
- Boundary values:
  - 0 and 2^WIDTH−1 (33554431) pass through unchanged on both inputs and both paths.
  - Values above 2^WIDTH−1 are not representable and need no handling.

Decomposition:
- Shared timer package: constant TIMER_W = 25 and the selector encoding SEL_IN1 = 1'b0, SEL_IN2 = 1'b1.
- One natural sub-module: mux2_bit (1-bit 2:1 mux), instantiated WIDTH times by generate.
- The output register stays in the top module.

Test Plan:
- sel=0, in1=180, in2=500 -> out=180 immediately; after the next edge, out_q=180, sel_q=0.
- sel=0 with in1=900/in2=100000, then in1=2500000/in2=300000 -> out=900, then out=2500000, checked every 1 ns.
- sel=1 with in1=400000/in2=8000000, then 231234/9902193, then 7958392/1203993 -> out=8000000, 9902193, 1203993; out_q matches each one cycle later.
- Extremes: in1=0, in2=33554431, toggle sel every 1 ns -> out alternates 0/33554431 with no stale value; all bits verified.
- Reset: rst=1 for two edges with sel=1, in2=9902193 -> out=9902193 throughout; out_q=0 and sel_q=0 during reset; out_q=9902193 one edge after rst drops.
- Randomized: 1000 random (in1, in2, sel) triples -> out always equals the selected input; out_q equals the previous-cycle selection.

Source files
------------

// File: rtl/mux_25bit_2way_pkg.sv
// Shared timer definitions: terminal-count word width and selector encoding.
package mux_25bit_2way_pkg;

  localparam int   TIMER_W = 25;
  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

endpackage : mux_25bit_2way_pkg

// File: rtl/mux_25bit_2way_mux2_bit.sv
// Single-bit 2:1 multiplexer; one slice of the terminal-count word selector.
module mux2_bit
  import mux_25bit_2way_pkg::*;
(
  input  logic in1,
  input  logic in2,
  input  logic sel,
  output logic out
);

  assign out = (sel == SEL_IN2) ? in2 : in1;

endmodule : mux2_bit

// File: rtl/mux_25bit_2way.sv
// Two-way terminal-count/preset selector for the two-mode timer, with a
// combinational output and a one-cycle registered copy plus aligned select.
module mux_25bit_2way
  import mux_25bit_2way_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q
);

  logic [WIDTH-1:0] out_p1;
  logic             sel_p1;

  // Stage 0: combinational bit-sliced select, independent of clk and rst
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2_bit u_mux2_bit (
      .in1 (in1[i]),
      .in2 (in2[i]),
      .sel (sel),
      .out (out[i])
    );
  end

  // Stage 1: registered copy; both word and select clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p1 <= '0;
      sel_p1 <= SEL_IN1;
    end else begin
      out_p1 <= out;
      sel_p1 <= sel;
    end
  end

  assign out_q = out_p1;
  assign sel_q = sel_p1;

endmodule : mux_25bit_2way

// File: tb/tb_mux_25bit_2way.sv
// Directed and random checks of the combinational and registered select paths.
module tb_mux_25bit_2way;

  localparam int W = 25;
  localparam logic [W-1:0] MAXV = 25'd33554431;

  logic         clk;
  logic         rst;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         sel;
  logic [W-1:0] out;
  logic [W-1:0] out_q;
  logic         sel_q;

  int checks;
  int failures;

  mux_25bit_2way #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .in1   (in1),
    .in2   (in2),
    .sel   (sel),
    .out   (out),
    .out_q (out_q),
    .sel_q (sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, checks=%0d required finish", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] a_tbl [3];
  logic [W-1:0] b_tbl [3];
  logic [W-1:0] exp_out;
  logic         exp_sel;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    in1 = '0;
    in2 = '0;
    sel = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset_out_q", out_q, '0);
    check("reset_sel_q", {24'd0, sel_q}, '0);
    rst = 1'b0;

    // Basic sel=0
    in1 = 25'd180; in2 = 25'd500; sel = 1'b0;
    #1 check("t1_out", out, 25'd180);
    tick();
    check("t1_out_q", out_q, 25'd180);
    check("t1_sel_q", {24'd0, sel_q}, 25'd0);

    // sel=0, values changing, checked every 1 ns
    in1 = 25'd900; in2 = 25'd100000;
    for (int i = 0; i < 3; i++) begin
      #1 check("t2a_out", out, 25'd900);
    end
    in1 = 25'd2500000; in2 = 25'd300000;
    for (int i = 0; i < 3; i++) begin
      #1 check("t2b_out", out, 25'd2500000);
    end
    tick();
    check("t2_out_q", out_q, 25'd2500000);

    // sel=1 directed triples
    a_tbl = '{25'd400000, 25'd231234,  25'd7958392};
    b_tbl = '{25'd8000000, 25'd9902193, 25'd1203993};
    sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in1 = a_tbl[i];
      in2 = b_tbl[i];
      #1 check("t3_out", out, b_tbl[i]);
      tick();
      check("t3_out_q", out_q, b_tbl[i]);
      check("t3_sel_q", {24'd0, sel_q}, 25'd1);
    end

    // Extremes with sel toggling every 1 ns
    in1 = '0; in2 = MAXV; sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 check("t4_out", out, sel ? MAXV : 25'd0);
      sel = ~sel;
    end
    tick();
    sel = 1'b1;
    tick();
    check("t4_out_q_max", out_q, MAXV);
    sel = 1'b0;
    tick();
    check("t4_out_q_zero", out_q, 25'd0);
    check("t4_sel_q", {24'd0, sel_q}, 25'd0);

    // Reset mid-operation: out keeps tracking, registers clear
    sel = 1'b1; in1 = 25'd12345; in2 = 25'd9902193;
    rst = 1'b1;
    #1 check("t5_out_rst", out, 25'd9902193);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t5_out_q_rst", out_q, 25'd0);
      check("t5_sel_q_rst", {24'd0, sel_q}, 25'd0);
      check("t5_out_during", out, 25'd9902193);
    end
    rst = 1'b0;
    tick();
    check("t5_out_q_rel", out_q, 25'd9902193);
    check("t5_sel_q_rel", {24'd0, sel_q}, 25'd1);

    // Random triples
    for (int i = 0; i < 1000; i++) begin
      in1 = W'($urandom);
      in2 = W'($urandom);
      sel = 1'($urandom);
      exp_out = sel ? in2 : in1;
      exp_sel = sel;
      #1 check("rnd_out", out, exp_out);
      tick();
      check("rnd_out_q", out_q, exp_out);
      check("rnd_sel_q", {24'd0, sel_q}, {24'd0, exp_sel});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule : tb_mux_25bit_2way
